// File: rtl/seq_left_rotator.sv
`default_nettype none
// ============================================================================
// Module   : seq_left_rotator
// Purpose  : Multi-cycle left barrel rotator, one log2 stage per clock,
//            with a start/busy/done handshake.
// Revision : 1.0
// ============================================================================
module seq_left_rotator #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [(1<<N)-1:0] a,
    input  logic [N-1:0]      amt,
    output logic [(1<<N)-1:0] y,
    output logic              busy,
    output logic              done
);

    localparam int W  = 1 << N;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] C_K_LAST = KW'(N - 1);
    localparam logic [N-1:0]  C_ONE    = N'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_data;
    logic [W-1:0]  r_y;
    logic [W-1:0]  w_stage;
    logic [N-1:0]  r_amt;
    logic [N-1:0]  w_sh;
    logic [N-1:0]  w_shr;
    logic [KW-1:0] r_k;

    // Stage k rotates by 2**k; the complementary right shift is W - 2**k,
    // which wraps to the two's complement of w_sh in N bits.
    assign w_sh    = C_ONE << r_k;
    assign w_shr   = ~w_sh + C_ONE;
    assign w_stage = r_amt[r_k] ? ((r_data << w_sh) | (r_data >> w_shr)) : r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_ROT;
                end
            end
            S_ROT: begin
                if (r_k == C_K_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_amt  <= '0;
            r_k    <= '0;
            r_y    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_data <= a;
                        r_amt  <= amt;
                        r_k    <= '0;
                    end
                end
                S_ROT: begin
                    r_data <= w_stage;
                    if (r_k == C_K_LAST) begin
                        r_y <= w_stage;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign y    = r_y;
    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_left_rotator.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_left_rotator
// Purpose  : Self-checking bench for seq_left_rotator (N=3, N=4, N=1).
// Revision : 1.0
// ============================================================================
module tb_seq_left_rotator;

    logic clk = 1'b0;
    logic reset;

    logic       start3;
    logic [7:0] a3;
    logic [2:0] amt3;
    logic [7:0] y3;
    logic       busy3;
    logic       done3;

    logic        start4;
    logic [15:0] a4;
    logic [3:0]  amt4;
    logic [15:0] y4;
    logic        busy4;
    logic        done4;

    logic       start1;
    logic [1:0] a1;
    logic [0:0] amt1;
    logic [1:0] y1;
    logic       busy1;
    logic       done1;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  model_y3;
    logic [7:0]  exp8;
    logic [7:0]  nxt_a;
    logic [2:0]  nxt_amt;

    typedef struct {
        logic [7:0] a;
        logic [2:0] amt;
        logic [7:0] y;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    seq_left_rotator #(.N(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .a(a3), .amt(amt3),
        .y(y3), .busy(busy3), .done(done3)
    );

    seq_left_rotator #(.N(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .amt(amt4),
        .y(y4), .busy(busy4), .done(done4)
    );

    seq_left_rotator #(.N(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .amt(amt1),
        .y(y1), .busy(busy1), .done(done1)
    );

    // Reference: bit i of the operand lands at position (i + s) mod w.
    function automatic logic [31:0] rotl_ref(input logic [31:0] x, input int s, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[(i + s) % w] = x[i];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic op8(input logic [7:0] va, input logic [2:0] vamt);
        logic [7:0] e;
        e = 8'(rotl_ref(32'(va), int'(vamt), 8));
        @(negedge clk);
        start3 = 1'b1; a3 = va; amt3 = vamt;
        @(posedge clk); #1;
        start3 = 1'b0; a3 = 8'($urandom); amt3 = 3'($urandom);
        chk("op8_busy_accept", 32'(busy3), 32'd1);
        chk("op8_done_accept", 32'(done3), 32'd0);
        for (int e_i = 1; e_i <= 4; e_i++) begin
            @(posedge clk); #1;
            if (e_i == 3) model_y3 = e;
            chk("op8_done", 32'(done3), 32'(e_i == 3));
            chk("op8_busy", 32'(busy3), 32'(e_i <= 3));
            chk("op8_y", 32'(y3), 32'(model_y3));
        end
    endtask

    task automatic op16(input logic [15:0] va, input logic [3:0] vamt);
        int cnt;
        @(negedge clk);
        start4 = 1'b1; a4 = va; amt4 = vamt;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = 16'($urandom); amt4 = 4'($urandom);
        cnt = 0;
        while (!done4 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("op16_latency", 32'(cnt), 32'd4);
        chk("op16_y", 32'(y4), rotl_ref(32'(va), int'(vamt), 16));
        @(posedge clk); #1;
        chk("op16_idle", {30'd0, busy4, done4}, 32'd0);
    endtask

    task automatic op2(input logic [1:0] va, input logic [0:0] vamt);
        int cnt;
        @(negedge clk);
        start1 = 1'b1; a1 = va; amt1 = vamt;
        @(posedge clk); #1;
        start1 = 1'b0; a1 = 2'($urandom); amt1 = 1'($urandom);
        cnt = 0;
        while (!done1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("op2_latency", 32'(cnt), 32'd1);
        chk("op2_y", 32'(y1), rotl_ref(32'(va), int'(vamt), 2));
        @(posedge clk); #1;
        chk("op2_idle", {30'd0, busy1, done1}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        start3 = 1'b0; a3 = '0; amt3 = '0;
        start4 = 1'b0; a4 = '0; amt4 = '0;
        start1 = 1'b0; a1 = '0; amt1 = '0;
        model_y3 = '0;

        tbl[0] = '{a: 8'h81, amt: 3'd1, y: 8'h03};
        tbl[1] = '{a: 8'hB4, amt: 3'd3, y: 8'hA5};
        tbl[2] = '{a: 8'h01, amt: 3'd7, y: 8'h80};
        tbl[3] = '{a: 8'h5A, amt: 3'd0, y: 8'h5A};
        tbl[4] = '{a: 8'h0F, amt: 3'd2, y: 8'h3C};
        tbl[5] = '{a: 8'hC3, amt: 3'd6, y: 8'hF0};

        #12;
        chk("rst_y3", 32'(y3), 32'd0);
        chk("rst_busy_done3", {30'd0, busy3, done3}, 32'd0);
        chk("rst_y4", 32'(y4), 32'd0);
        chk("rst_y1", 32'(y1), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            op8(tbl[i].a, tbl[i].amt);
            chk("tbl_y", 32'(y3), 32'(tbl[i].y));
        end

        // Reset in the middle of an operation, between clock edges.
        @(negedge clk);
        start3 = 1'b1; a3 = 8'hC3; amt3 = 3'd6;
        @(posedge clk); #1;
        start3 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_y3 = '0;
        chk("midrst_busy", 32'(busy3), 32'd0);
        chk("midrst_done", 32'(done3), 32'd0);
        chk("midrst_y", 32'(y3), 32'd0);
        for (int e_i = 0; e_i < 3; e_i++) begin
            @(posedge clk); #1;
            chk("midrst_hold", {22'd0, y3, busy3, done3}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        op8(8'hC3, 3'd6);
        chk("midrst_redo_y", 32'(y3), 32'hF0);

        // A start while busy is ignored; a held start relaunches after DONE.
        @(negedge clk);
        start3 = 1'b1; a3 = 8'h0F; amt3 = 3'd2;
        @(posedge clk); #1;
        start3 = 1'b0;
        chk("ign_busy", 32'(busy3), 32'd1);
        @(negedge clk);
        start3 = 1'b1; a3 = 8'hFF; amt3 = 3'd5;
        for (int e_i = 1; e_i <= 3; e_i++) begin
            @(posedge clk); #1;
            if (e_i == 3) model_y3 = 8'h3C;
            chk("ign_done", 32'(done3), 32'(e_i == 3));
            chk("ign_y", 32'(y3), 32'(model_y3));
        end
        a3 = 8'h12; amt3 = 3'd5;
        @(posedge clk); #1;
        chk("ign_idle", {30'd0, busy3, done3}, 32'd0);
        @(posedge clk); #1;
        chk("ign_relaunch", {30'd0, busy3, done3}, 32'd2);
        start3 = 1'b0; a3 = 8'h00; amt3 = 3'd0;
        for (int e_i = 1; e_i <= 3; e_i++) begin
            @(posedge clk); #1;
            if (e_i == 3) model_y3 = 8'(rotl_ref(32'h12, 5, 8));
            chk("ign2_done", 32'(done3), 32'(e_i == 3));
            chk("ign2_y", 32'(y3), 32'(model_y3));
        end
        @(posedge clk); #1;
        chk("ign2_idle", {30'd0, busy3, done3}, 32'd0);

        // Exhaustive back-to-back with start held high and garbage inputs in flight.
        @(negedge clk);
        start3 = 1'b1; a3 = 8'h00; amt3 = 3'd0;
        for (int idx = 0; idx < 2048; idx++) begin
            exp8 = 8'(rotl_ref(32'(idx >> 3), idx % 8, 8));
            for (int j = 0; j < 5; j++) begin
                @(posedge clk); #1;
                if (j == 0) begin
                    a3 = 8'($urandom); amt3 = 3'($urandom);
                end
                if (j == 3) model_y3 = exp8;
                chk("exh_done", 32'(done3), 32'(j == 3));
                chk("exh_busy", 32'(busy3), 32'(j != 4));
                chk("exh_y", 32'(y3), 32'(model_y3));
                if (j == 4) begin
                    if (idx < 2047) begin
                        nxt_a   = 8'((idx + 1) >> 3);
                        nxt_amt = 3'((idx + 1) % 8);
                        a3 = nxt_a; amt3 = nxt_amt;
                    end else begin
                        start3 = 1'b0;
                    end
                end
            end
        end

        // Wider and narrowest instances.
        op16(16'h8001, 4'd15);
        chk("n4_corner_y", 32'(y4), 32'hC000);
        op2(2'b01, 1'b1);
        chk("n1_corner_y", 32'(y1), 32'd2);
        for (int i = 0; i < 60; i++) begin
            op16(16'($urandom), 4'($urandom));
            op2(2'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
